bip_program_loader: RTL

Sequential loader that fills the BIP program memory from a byte stream (UART receiver side) before execution. It assembles 16-bit instruction words (opcode[15:11], operand[10:0]), writes them to consecutive program-memory addresses starting at 0, and releases the CPU once a HALT word has been stored. It is the producer of the instruction stream that the BIP instruction decoder consumes.

---
 rtl/bip_pkg.sv | 41 ++++
 rtl/bip_program_loader.sv | 120 ++++++++++++
 2 files changed

// File: rtl/bip_pkg.sv
// ============================================================================
// bip_pkg : shared BIP widths, opcode constants and loader state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package bip_pkg;

  localparam int ADDR_W   = 11;
  localparam int DATA_W   = 16;
  localparam int OPCODE_W = 5;

  localparam logic [OPCODE_W-1:0] OP_HALT = 5'd0;
  localparam logic [OPCODE_W-1:0] OP_STO  = 5'd1;
  localparam logic [OPCODE_W-1:0] OP_LD   = 5'd2;
  localparam logic [OPCODE_W-1:0] OP_LDI  = 5'd3;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 5'd4;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 5'd5;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 5'd6;
  localparam logic [OPCODE_W-1:0] OP_SUBI = 5'd7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RX_HI = 3'd1,
    ST_RX_LO = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } loader_state_e;

  function automatic logic is_legal_opcode(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_HALT, OP_STO, OP_LD, OP_LDI,
      OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/bip_program_loader.sv
// ============================================================================
// bip_program_loader : fills BIP program memory from a byte stream, releases
// the CPU once HALT is stored. Option macro: BIP_LOADER_OPCHECK_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module bip_program_loader #(
  parameter int ADDR_W    = bip_pkg::ADDR_W,
  parameter int DATA_W    = bip_pkg::DATA_W,
  parameter int OPCODE_W  = bip_pkg::OPCODE_W,
  parameter int MEM_DEPTH = 2048
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              START,
  input  logic [7:0]        RX_DATA,
  input  logic              RX_VALID,
  output logic              RX_READY,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  output logic              CPU_HOLD,
  output logic              LOAD_DONE,
  output logic              LOAD_ERR,
  output logic [ADDR_W:0]   WORD_COUNT
);

  import bip_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  loader_state_e     state_q, state_d;
  logic [DATA_W-1:0] word_q,  word_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [ADDR_W:0]   count_q, count_d;

  logic [OPCODE_W-1:0] opcode;
  logic                opcode_ok;

  assign opcode = word_q[DATA_W-1 -: OPCODE_W];

`ifdef BIP_LOADER_OPCHECK_EN
  assign opcode_ok = is_legal_opcode(opcode);
`else
  assign opcode_ok = 1'b1;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      addr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    addr_d  = addr_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (START) begin
          state_d = ST_RX_HI;
          addr_d  = '0;
          count_d = '0;
        end
      end
      ST_RX_HI: begin
        if (RX_VALID) begin
          word_d[DATA_W-1 -: 8] = RX_DATA;
          state_d               = ST_RX_LO;
        end
      end
      ST_RX_LO: begin
        if (RX_VALID) begin
          word_d[7:0] = RX_DATA;
          state_d     = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (!opcode_ok) begin
          state_d = ST_ERROR;
        end else begin
          count_d = count_q + {{ADDR_W{1'b0}}, 1'b1};
          if (opcode == OP_HALT) begin
            state_d = ST_DONE;
          end else if (addr_q == LAST_ADDR) begin
            // memory full without a HALT: stop rather than wrap
            state_d = ST_ERROR;
          end else begin
            addr_d  = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            state_d = ST_RX_HI;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // every output decodes registered state only, so RX_VALID never reaches RX_READY
  assign RX_READY   = (state_q == ST_RX_HI) || (state_q == ST_RX_LO);
  assign MEM_WE     = (state_q == ST_WRITE) && opcode_ok;
  assign MEM_ADDR   = addr_q;
  assign MEM_WDATA  = word_q;
  assign CPU_HOLD   = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign LOAD_DONE  = (state_q == ST_DONE);
  assign LOAD_ERR   = (state_q == ST_ERROR);
  assign WORD_COUNT = count_q;

endmodule

`default_nettype wire
